// File: rtl/game_pkg.sv
// Shared encodings and grid geometry for the game controller and the sprite renderer.
package game_pkg;

   typedef enum logic [2:0] {
      PLAYING   = 3'b000,
      YOU_WIN   = 3'b001,
      GAME_OVER = 3'b010
   } gameplay_t;

   localparam int GRID_COLS          = 20;
   localparam int SHIP_ROW           = 13;
   localparam int BULLET_START_ROW   = 12;
   localparam int INVADER_START_LINE = 1;
   localparam int SHIP_START_X       = 10;

   localparam logic [GRID_COLS-1:0] INVADERS_FULL = '1;

endpackage

// File: rtl/tick_divider.sv
// Counts frame ticks while enabled and pulses fire combinationally on every PERIOD-th tick.
module tick_divider #(
   parameter int PERIOD = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic tick,
   output logic fire
);

   localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] r_count;
   logic         w_advance;
   logic         w_atLast;

   assign w_advance = enable & tick;
   assign w_atLast  = (r_count == LAST);
   assign fire      = w_advance & w_atLast;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (w_advance) begin
         r_count <= w_atLast ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/game_controller.sv
// Space-invaders style game state machine, updated once per frame tick.
// Define GAME_CTRL_RESTART_EN to let a fire press restart the game from a terminal state.
module game_controller
   import game_pkg::*;
#(
   parameter int INVADER_PERIOD = 30,
   parameter int BULLET_PERIOD  = 2,
   parameter int SHIP_PERIOD    = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 frame_tick,
   input  logic                 btn_left,
   input  logic                 btn_right,
   input  logic                 btn_fire,
   output logic [GRID_COLS-1:0] invaders_array,
   output logic [3:0]           invaders_line,
   output logic [4:0]           ship_x,
   output logic [4:0]           bullet_x,
   output logic [3:0]           bullet_y,
   output logic                 bullet_flying,
   output logic [2:0]           gameplay
);

   gameplay_t            r_state, w_nState;
   logic [GRID_COLS-1:0] r_invaders, w_nInvaders;
   logic [3:0]           r_line, w_nLine;
   logic [4:0]           r_shipX, w_nShipX;
   logic [4:0]           r_bulletX, w_nBulletX;
   logic [3:0]           r_bulletY, w_nBulletY;
   logic                 r_flying, w_nFlying;
   logic                 r_firePending;
   logic                 r_btnFirePrev;

   logic w_playing, w_fireEdge, w_restart, w_divReset, w_launched;
   logic w_invEv, w_bulEv, w_shipEv;

   assign w_playing  = (r_state == PLAYING);
   assign w_fireEdge = btn_fire & ~r_btnFirePrev;

`ifdef GAME_CTRL_RESTART_EN
   assign w_restart = frame_tick & r_firePending & ~w_playing;
`else
   assign w_restart = 1'b0;
`endif

   assign w_divReset = reset | w_restart;

   tick_divider #(.PERIOD(INVADER_PERIOD)) uInvaderDiv (
      .clk(clk), .reset(w_divReset), .enable(w_playing), .tick(frame_tick), .fire(w_invEv)
   );
   tick_divider #(.PERIOD(BULLET_PERIOD)) uBulletDiv (
      .clk(clk), .reset(w_divReset), .enable(w_playing), .tick(frame_tick), .fire(w_bulEv)
   );
   tick_divider #(.PERIOD(SHIP_PERIOD)) uShipDiv (
      .clk(clk), .reset(w_divReset), .enable(w_playing), .tick(frame_tick), .fire(w_shipEv)
   );

   // Each stage sees the results of the stages before it: ship, fire, bullet, invader, status.
   always_comb begin
      w_nState    = r_state;
      w_nInvaders = r_invaders;
      w_nLine     = r_line;
      w_nShipX    = r_shipX;
      w_nBulletX  = r_bulletX;
      w_nBulletY  = r_bulletY;
      w_nFlying   = r_flying;
      w_launched  = 1'b0;
      if (frame_tick && w_playing) begin
         if (w_shipEv && (btn_left ^ btn_right)) begin
            if (btn_right && (w_nShipX != 5'(GRID_COLS - 1))) begin
               w_nShipX = w_nShipX + 1'b1;
            end else if (btn_left && (w_nShipX != 5'd0)) begin
               w_nShipX = w_nShipX - 1'b1;
            end
         end
         if (r_firePending && !w_nFlying) begin
            w_nBulletX = w_nShipX;
            w_nBulletY = 4'(BULLET_START_ROW);
            w_nFlying  = 1'b1;
            w_launched = 1'b1;
         end
         if (w_bulEv && w_nFlying && !w_launched) begin
            if ((w_nBulletY == w_nLine) && w_nInvaders[w_nBulletX]) begin
               w_nInvaders[w_nBulletX] = 1'b0;
               w_nFlying               = 1'b0;
            end else if (w_nBulletY == 4'd0) begin
               w_nFlying = 1'b0;
            end else begin
               w_nBulletY = w_nBulletY - 1'b1;
            end
         end
         // A descending row can run into a bullet that is sitting on the new line.
         if (w_invEv) begin
            w_nLine = w_nLine + 1'b1;
            if ((w_nLine == w_nBulletY) && w_nFlying && w_nInvaders[w_nBulletX]) begin
               w_nInvaders[w_nBulletX] = 1'b0;
               w_nFlying               = 1'b0;
            end
         end
         if (w_nInvaders == '0) begin
            w_nState  = YOU_WIN;
            w_nFlying = 1'b0;
         end else if (w_nLine == 4'(SHIP_ROW)) begin
            w_nState  = GAME_OVER;
            w_nFlying = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset || w_restart) begin
         r_state       <= PLAYING;
         r_invaders    <= INVADERS_FULL;
         r_line        <= 4'(INVADER_START_LINE);
         r_shipX       <= 5'(SHIP_START_X);
         r_bulletX     <= 5'd0;
         r_bulletY     <= 4'd0;
         r_flying      <= 1'b0;
         r_firePending <= 1'b0;
         r_btnFirePrev <= 1'b0;
      end else begin
         r_state       <= w_nState;
         r_invaders    <= w_nInvaders;
         r_line        <= w_nLine;
         r_shipX       <= w_nShipX;
         r_bulletX     <= w_nBulletX;
         r_bulletY     <= w_nBulletY;
         r_flying      <= w_nFlying;
         r_btnFirePrev <= btn_fire;
         if (frame_tick) begin
            r_firePending <= 1'b0;
         end else if (w_fireEdge) begin
            r_firePending <= 1'b1;
         end
      end
   end

   assign invaders_array = r_invaders;
   assign invaders_line  = r_line;
   assign ship_x         = r_shipX;
   assign bullet_x       = r_bulletX;
   assign bullet_y       = r_bulletY;
   assign bullet_flying  = r_flying;
   assign gameplay       = r_state;

endmodule
